// File: rtl/mem_port_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto one shared memory port.
// Data wins contention unless the fetch side has lost STARVE_LIMIT contested grants in a row.
module mem_port_arbiter #(
  parameter int N            = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         if_req,
  input  logic [N-1:0] if_addr,
  input  logic         d_req,
  input  logic         d_we,
  input  logic [N-1:0] d_addr,
  input  logic [N-1:0] d_wdata,
  input  logic         mem_ready,
  input  logic [N-1:0] mem_rdata,
  output logic         mem_req,
  output logic         mem_we,
  output logic         mem_sel,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  output logic         if_done,
  output logic [N-1:0] if_rdata,
  output logic         d_done,
  output logic [N-1:0] d_rdata,
  output logic         if_stall
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          sel_q, sel_d;
  logic [N-1:0]  ia_q, ia_d;
  logic [N-1:0]  da_q, da_d;
  logic          dwe_q, dwe_d;
  logic [N-1:0]  dwd_q, dwd_d;
  logic          take_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
      sel_q    <= 1'b0;
      ia_q     <= '0;
      da_q     <= '0;
      dwe_q    <= 1'b0;
      dwd_q    <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      sel_q    <= sel_d;
      ia_q     <= ia_d;
      da_q     <= da_d;
      dwe_q    <= dwe_d;
      dwd_q    <= dwd_d;
    end
  end

  // Data takes the port unless fetch is also waiting and has hit the starvation limit.
  assign take_d = d_req & (~if_req | (starve_q != LIM));

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    sel_d    = sel_q;
    ia_d     = ia_q;
    da_d     = da_q;
    dwe_d    = dwe_q;
    dwd_d    = dwd_q;
    case (state_q)
      IDLE: begin
        if (take_d) begin
          state_d = SERVE_D;
          sel_d   = 1'b1;
          da_d    = d_addr;
          dwe_d   = d_we;
          dwd_d   = d_wdata;
          if (if_req && starve_q != LIM) starve_d = starve_q + 1'b1;
        end else if (if_req) begin
          state_d  = SERVE_I;
          sel_d    = 1'b0;
          ia_d     = if_addr;
          starve_d = '0;
        end
      end
      SERVE_I, SERVE_D: if (mem_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = (state_q != IDLE);
    mem_we    = (state_q == SERVE_D) & dwe_q;
    mem_sel   = sel_q;
    mem_addr  = sel_q ? da_q : ia_q;
    mem_wdata = dwd_q;
    if_done   = (state_q == SERVE_I) & mem_ready;
    d_done    = (state_q == SERVE_D) & mem_ready;
    if_rdata  = mem_rdata;
    d_rdata   = mem_rdata;
    if_stall  = if_req & ~if_done;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle vector table plus contention/idle sequences.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst, if_req, d_req, d_we, mem_ready;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        mem_req, mem_we, mem_sel, if_done, d_done, if_stall;
  logic [31:0] mem_addr, mem_wdata, if_rdata, d_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.N(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .if_done(if_done), .if_rdata(if_rdata), .d_done(d_done),
    .d_rdata(d_rdata), .if_stall(if_stall)
  );

  typedef struct {
    logic        rst, if_req;
    logic [31:0] if_addr;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_req, e_we, e_sel;
    logic [31:0] e_addr, e_wdata;
    logic        e_idone, e_ddone, e_stall;
  } vec_t;

  vec_t vec [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the next serve cycle and check who got the port.
  task automatic grant_check(input logic exp_sel, input string nm);
    int k = 0;
    @(negedge clk);
    while (!mem_req && k < 4) begin
      tick();
      @(negedge clk);
      k++;
    end
    chk({nm, "_req"}, {31'd0, mem_req}, 32'd1);
    chk({nm, "_sel"}, {31'd0, mem_sel}, {31'd0, exp_sel});
    chk({nm, "_done"}, {31'd0, exp_sel ? d_done : if_done}, 32'd1);
    tick();
  endtask

  task automatic contend(input int n, input string pat, input string nm);
    for (int g = 0; g < n; g++) begin
      string ch;
      ch = pat.substr(g, g);
      grant_check(ch == "D", $sformatf("%s_g%0d", nm, g));
    end
  endtask

  initial begin
    //          rst if  if_addr       dreq we d_addr        d_wdata       rdy rdata          req we sel addr          wdata         idn ddn stall
    vec[0]  = '{0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 0, 32'h0,        32'h0,        0, 0, 0};
    vec[1]  = '{0, 1, 32'h100,      0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 0, 32'h0,        32'h0,        0, 0, 1};
    vec[2]  = '{0, 1, 32'h100,      0, 0, 32'h0,        32'h0,        1, 32'h11112222, 1, 0, 0, 32'h100,      32'h0,        1, 0, 0};
    vec[3]  = '{0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        1, 32'h0,        0, 0, 0, 32'h100,      32'h0,        0, 0, 0};
    vec[4]  = '{0, 0, 32'h0,        1, 1, 32'h2000,     32'hDEADBEEF, 0, 32'h0,        0, 0, 0, 32'h100,      32'h0,        0, 0, 0};
    vec[5]  = '{0, 0, 32'h0,        1, 0, 32'h3000,     32'h12345678, 0, 32'h0,        1, 1, 1, 32'h2000,     32'hDEADBEEF, 0, 0, 0};
    vec[6]  = '{0, 0, 32'h0,        1, 0, 32'h3000,     32'h12345678, 0, 32'h0,        1, 1, 1, 32'h2000,     32'hDEADBEEF, 0, 0, 0};
    vec[7]  = '{0, 0, 32'h0,        1, 0, 32'h3000,     32'h12345678, 1, 32'hAAAA5555, 1, 1, 1, 32'h2000,     32'hDEADBEEF, 0, 1, 0};
    vec[8]  = '{0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        1, 32'h0,        0, 0, 1, 32'h2000,     32'hDEADBEEF, 0, 0, 0};
    vec[9]  = '{0, 0, 32'h0,        1, 0, 32'h40,       32'h5,        0, 32'h0,        0, 0, 1, 32'h2000,     32'hDEADBEEF, 0, 0, 0};
    vec[10] = '{0, 0, 32'h0,        1, 0, 32'h40,       32'h5,        0, 32'h0,        1, 0, 1, 32'h40,       32'h5,        0, 0, 0};
    vec[11] = '{1, 0, 32'h0,        1, 0, 32'h40,       32'h5,        0, 32'h0,        1, 0, 1, 32'h40,       32'h5,        0, 0, 0};
    vec[12] = '{0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        1, 32'h0,        0, 0, 0, 32'h0,        32'h0,        0, 0, 0};

    rst = 1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    mem_ready = 0; mem_rdata = 0;
    tick();

    for (int i = 0; i < 13; i++) begin
      rst = vec[i].rst; if_req = vec[i].if_req; if_addr = vec[i].if_addr;
      d_req = vec[i].d_req; d_we = vec[i].d_we; d_addr = vec[i].d_addr;
      d_wdata = vec[i].d_wdata; mem_ready = vec[i].rdy; mem_rdata = vec[i].rdata;
      @(negedge clk);
      chk($sformatf("v%0d_mem_req", i),   {31'd0, mem_req},  {31'd0, vec[i].e_req});
      chk($sformatf("v%0d_mem_we", i),    {31'd0, mem_we},   {31'd0, vec[i].e_we});
      chk($sformatf("v%0d_mem_sel", i),   {31'd0, mem_sel},  {31'd0, vec[i].e_sel});
      chk($sformatf("v%0d_mem_addr", i),  mem_addr,          vec[i].e_addr);
      chk($sformatf("v%0d_mem_wdata", i), mem_wdata,         vec[i].e_wdata);
      chk($sformatf("v%0d_if_done", i),   {31'd0, if_done},  {31'd0, vec[i].e_idone});
      chk($sformatf("v%0d_d_done", i),    {31'd0, d_done},   {31'd0, vec[i].e_ddone});
      chk($sformatf("v%0d_if_stall", i),  {31'd0, if_stall}, {31'd0, vec[i].e_stall});
      if (vec[i].e_idone) chk($sformatf("v%0d_if_rdata", i), if_rdata, vec[i].rdata);
      if (vec[i].e_ddone) chk($sformatf("v%0d_d_rdata", i),  d_rdata,  vec[i].rdata);
      tick();
    end

    // Idle noise: ready strobes with nothing requested must not start or finish anything.
    rst = 0; if_req = 0; d_req = 0; mem_ready = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("idle%0d_req", c),   {31'd0, mem_req}, 32'd0);
      chk($sformatf("idle%0d_idone", c), {31'd0, if_done}, 32'd0);
      chk($sformatf("idle%0d_ddone", c), {31'd0, d_done},  32'd0);
      tick();
    end

    // Contention from a cleared starvation count; leaves the count at 2.
    if_req = 1; if_addr = 32'h400; d_req = 1; d_we = 0; d_addr = 32'h800; mem_ready = 1;
    contend(12, "DDDDIDDDDIDD", "cont");

    // Uncontested fetch must clear the count, so four more data wins follow.
    d_req = 0;
    grant_check(1'b0, "fetch_only");
    d_req = 1;
    contend(5, "DDDDI", "post");

    if_req = 0; d_req = 0; mem_ready = 0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: N, 32, address/data width.
REQ-002 Parameter: STARVE_LIMIT, 4, consecutive contested data grants before instruction side is forced.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous reset, active-high.
REQ-005 if_req  in  1  instruction-fetch access request.
REQ-006 if_addr  in  N  fetch address.
REQ-007 d_req  in  1  data (load/store) access request.
REQ-008 d_we  in  1  data write enable (1 = store).
REQ-009 d_addr  in  N  data address.
REQ-010 d_wdata  in  N  store data.
REQ-011 mem_ready  in  1  shared memory completes current access this cycle.
REQ-012 mem_rdata  in  N  shared memory read data, valid when mem_ready=1.
REQ-013 mem_req  out  1  access active to shared memory.
REQ-014 mem_we  out  1  write strobe to shared memory.
REQ-015 mem_sel  out  1  port 2:1 mux select; 1 = data side, 0 = instruction side.
REQ-016 mem_addr  out  N  muxed latched address.
REQ-017 mem_wdata  out  N  latched store data.
REQ-018 if_done  out  1  fetch completes this cycle.
REQ-019 if_rdata  out  N  fetch data, valid with if_done.
REQ-020 d_done  out  1  data access completes this cycle.
REQ-021 d_rdata  out  N  load data, valid with d_done.
REQ-022 if_stall  out  1  fetch pending: if_req & ~if_done.

Function
REQ-023 FSM states SHALL be IDLE, SERVE_I, SERVE_D; arbitration occurs only in IDLE.
REQ-024 IDLE, neither req -> stay IDLE, mem_req=0.
REQ-025 IDLE, one req -> that side granted; next state SERVE_I or SERVE_D.
REQ-026 IDLE, both req -> data granted unless starve_cnt == STARVE_LIMIT, then instruction granted.
REQ-027 On grant edge: latch address, d_we, d_wdata of granted side; mem_sel <= granted side (1 data, 0 instr).
REQ-028 mem_addr SHALL equal mem_sel ? latched d_addr : latched if_addr; mem_wdata = latched d_wdata.
REQ-029 SERVE_x: mem_req=1; mem_we = (SERVE_D & latched d_we); stay until mem_ready=1.
REQ-030 x_done = (state==SERVE_x) & mem_ready, combinational; x_rdata = mem_rdata passthrough; done is a single-cycle pulse.
REQ-031 Completion cycle -> next state IDLE; minimum request-to-request spacing 2 cycles per access (grant cycle + serve cycle).
REQ-032 Requester SHALL hold req until done and deassert it the cycle after done; req still high after done = new request.
REQ-033 Input operands changing during SERVE_x SHALL NOT affect mem_addr/mem_wdata/mem_we.
REQ-034 starve_cnt (width ceil(log2(STARVE_LIMIT+1))): +1 on data grant while if_req=1, saturating at STARVE_LIMIT; cleared on instruction grant; unchanged otherwise.
REQ-035 mem_ready in IDLE SHALL be ignored; no done pulses.
REQ-036 mem_sel SHALL hold last grant value while IDLE.
REQ-037 Stores: d_done asserted; d_rdata content don't-care.

Reset
REQ-038 rst=1 at edge: state IDLE, starve_cnt 0, mem_sel 0, latched addr/data/we 0; rst overrides all other inputs.
REQ-039 After reset: mem_req 0, mem_we 0, if_done 0, d_done 0, mem_addr 0, mem_wdata 0.
REQ-040 Reset mid-SERVE SHALL abandon access: no done pulse, mem_req 0 next cycle, no counter update.

Verification
REQ-041 Fetch only: if_req=1, if_addr=0x100, mem_ready same cycle as SERVE_I -> cycle1 mem_req=1, mem_sel=0, mem_addr=0x100, if_done=1, if_rdata=mem_rdata; cycle2 IDLE.
REQ-042 Store: d_req=1, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, mem_ready after 3 serve cycles -> mem_we=1, mem_sel=1 for 3 cycles, d_done single pulse, operand change mid-serve not reflected.
REQ-043 Contention: both req held continuously, STARVE_LIMIT=4, mem_ready=1 every serve -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-044 Fetch-only after contention: instruction grant clears starve_cnt to 0; subsequent contested grant goes to data.
REQ-045 Reset in SERVE_D with mem_ready=0, then mem_ready=1 -> no d_done, mem_req=0, state IDLE, mem_sel=0.
REQ-046 Idle noise: mem_ready=1, no reqs, 10 cycles -> mem_req, if_done, d_done all 0.
